moore_seq_rom_gen: RTL and testbench
====================================

# moore_seq_rom_gen

Parametrised table-driven Moore sequence generator, successor to the fixed 3-bit ROM counter. A registered index walks a DEPTH-entry output table up or down, in free-running or one-shot mode, with index load and a runtime table-write port. Serves as the generic pattern/count source for the lab's FSM and display blocks.

## Interface
- WIDTH, 3, width of each table entry and of count
- DEPTH, 8, number of table entries/states; any value ≥ 2, not limited to powers of two
- ADDR_W, $clog2(DEPTH), index width; derived, never overridden
- clk  in  1  rising-edge clock, sole clock domain
- reset  in  1  synchronous, active-low; sampled on rising clk
- en  in  1  advance one step this cycle
- dir  in  1  0 = up (index+1), 1 = down (index−1)
- oneshot  in  1  0 = wrap at ends, 1 = stop at terminal index
- load  in  1  jump index to load_idx
- load_idx  in  ADDR_W  target index for load
- wr_en  in  1  write table entry
- wr_idx  in  ADDR_W  entry to write
- wr_data  in  WIDTH  value to write
- count  out  WIDTH  registered table[idx]
- idx  out  ADDR_W  registered current index
- tc  out  1  one-cycle terminal pulse
- done  out  1  sticky one-shot completion flag

## Operation
- Table: DEPTH registers of WIDTH bits. Reset loads default entry i = (i ^ (i>>1)) truncated to WIDTH (Gray code); DEPTH=8, WIDTH=3 gives 0,1,3,2,6,7,5,4.
- Reset values: idx=0, count=table default[0]=0, tc=0, done=0.
- Priority per cycle: reset > load > en step > hold.
- load: idx←load_idx, count←table[load_idx], done←0, tc←0. load_idx ≥ DEPTH: entire load ignored; en step is then evaluated as if load were low.
- Step (en=1, no load): nxt = idx±1 per dir.
  - oneshot=0: up from DEPTH−1 → 0, down from 0 → DEPTH−1; tc=1 in the cycle after a wrap step.
  - oneshot=1: terminal index is DEPTH−1 (up) or 0 (down). Step landing on terminal sets done=1 and pulses tc. At terminal (for current dir) en is ignored; idx, count hold, tc=0. Reversing dir while done=1 is allowed; steps proceed, done stays 1 until load/reset.
- en=0, no load: idx, count hold; tc=0.
- Table write: wr_en with wr_idx < DEPTH updates entry at clock edge; wr_idx ≥ DEPTH ignored. Write-first bypass: if the same edge loads count from the entry being written, count takes wr_data.
- Write to the entry currently held in count does not refresh count; new value appears next time that index is entered.
- Changing oneshot mid-run takes effect on the next step; done is not cleared by it.

## Timing
- All outputs registered; en/load/dir → idx, count, tc, done visible after one rising edge (latency 1).
- tc is high exactly one cycle per qualifying step; back-to-back wraps (DEPTH=2, continuous en) give tc high on alternate cycles only when wrapping.
- reset low for one edge fully reinitialises, including table contents, regardless of load/en/wr_en that cycle.
- Reset asserted mid-sequence: next cycle idx=0, count=0, done=0, tc=0.

## Test plan
- Reset, then en=1, dir=0, oneshot=0 for 10 cycles (defaults) -> count 1,3,2,6,7,5,4,0,1,3; idx 1..7,0,1,2; tc high only the cycle count returns to 0.
- dir=1 from reset, 3 steps -> idx 7,6,5, count 4,5,7; tc on first step (wrap 0→7).
- oneshot=1, dir=0, en held 12 cycles -> idx stops at 7, count 4, done=1 and tc pulse on arrival, held thereafter; then load=1, load_idx=2 -> idx 2, count 3, done 0.
- wr_en, wr_idx=3, wr_data=5 while load, load_idx=3 same cycle -> count=5 next cycle; wr_idx=3 again with DEPTH=8 and load_idx=9 (ADDR_W ext in DEPTH=5 build) -> load ignored.
- DEPTH=5, WIDTH=4 build, free-run up -> count 0,1,3,2,6,0…, wrap at idx 4→0 with tc.
- Mid-sequence reset low one cycle alongside en and wr_en -> idx 0, count 0, table back to defaults (written entry reads default).

Source files
------------

// File: rtl/moore_seq_rom_gen.sv
// moore_seq_rom_gen
//   Table-driven Moore sequence generator. A registered index walks a
//   DEPTH-entry table up or down, either wrapping or stopping at the terminal
//   index. The index can be loaded directly, and table entries can be written
//   at runtime.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-low; also restores the Gray-code table
//   en       advance one step this cycle
//   dir      0 = up, 1 = down
//   oneshot  0 = wrap at the ends, 1 = stop at the terminal index
//   load     jump to load_idx; ignored when load_idx >= DEPTH
//   load_idx target index for load
//   wr_en    write wr_data into entry wr_idx; ignored when wr_idx >= DEPTH
//   wr_idx   entry to write
//   wr_data  value to write
//   count    registered table[idx]
//   idx      registered current index
//   tc       one-cycle terminal pulse (wrap, or one-shot arrival)
//   done     sticky one-shot completion flag, cleared by load or reset
module moore_seq_rom_gen #(
  parameter  int unsigned WIDTH  = 3,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              dir,
  input  logic              oneshot,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_idx,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  count,
  output logic [ADDR_W-1:0] idx,
  output logic              tc,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  table_q [DEPTH];
  logic              load_in_range;
  logic              wr_in_range;
  logic              at_end;
  logic              load_ok;
  logic              step;
  logic              wr_ok;
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W-1:0] target;
  logic [WIDTH-1:0]  rd_data;

  // With a power-of-two depth every index is valid; comparing would be constant.
  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign load_in_range = 1'b1;
    assign wr_in_range   = 1'b1;
  end else begin : g_npow2
    assign load_in_range = (load_idx <= LAST);
    assign wr_in_range   = (wr_idx <= LAST);
  end

  always_comb begin
    at_end  = dir ? (idx == '0) : (idx == LAST);
    if (dir) begin
      nxt = at_end ? LAST : idx - ADDR_W'(1);
    end else begin
      nxt = at_end ? '0 : idx + ADDR_W'(1);
    end
    load_ok = load & load_in_range;
    wr_ok   = wr_en & wr_in_range;
    // In one-shot mode the end for the current direction is the terminal index.
    step    = en & ~load_ok & ~(oneshot & at_end);
    target  = load_ok ? load_idx : nxt;
    // Write-first: an entry written on the same edge it is read shows the new value.
    rd_data = (wr_ok && (wr_idx == target)) ? wr_data : table_q[target];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[ADDR_W'(i)] <= WIDTH'(i ^ (i >> 1));
      end
      idx   <= '0;
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (wr_ok) begin
        table_q[wr_idx] <= wr_data;
      end
      tc <= 1'b0;
      if (load_ok) begin
        idx   <= load_idx;
        count <= rd_data;
        done  <= 1'b0;
      end else if (step) begin
        idx   <= nxt;
        count <= rd_data;
        if (!oneshot && at_end) begin
          tc <= 1'b1;
        end
        if (oneshot && (nxt == (dir ? '0 : LAST))) begin
          tc   <= 1'b1;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_moore_seq_rom_gen.sv
// tb_moore_seq_rom_gen
//   Directed bench for moore_seq_rom_gen with three builds:
//   a: DEPTH=8 WIDTH=3, b: DEPTH=5 WIDTH=4, c: DEPTH=2 WIDTH=3.
module tb_moore_seq_rom_gen;

  logic clk;
  int   checks;
  int   errors;

  // build a
  logic       reset_a, en_a, dir_a, oneshot_a, load_a, wr_en_a;
  logic [2:0] load_idx_a, wr_idx_a, wr_data_a;
  logic [2:0] count_a, idx_a;
  logic       tc_a, done_a;

  // build b
  logic       reset_b, en_b, dir_b, oneshot_b, load_b, wr_en_b;
  logic [2:0] load_idx_b, wr_idx_b;
  logic [3:0] wr_data_b, count_b;
  logic [2:0] idx_b;
  logic       tc_b, done_b;

  // build c
  logic       reset_c, en_c;
  logic [2:0] count_c;
  logic [0:0] idx_c;
  logic       tc_c, done_c;

  logic [2:0] g8 [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  moore_seq_rom_gen u_a (
    .clk(clk), .reset(reset_a), .en(en_a), .dir(dir_a), .oneshot(oneshot_a),
    .load(load_a), .load_idx(load_idx_a), .wr_en(wr_en_a), .wr_idx(wr_idx_a),
    .wr_data(wr_data_a), .count(count_a), .idx(idx_a), .tc(tc_a), .done(done_a)
  );

  moore_seq_rom_gen #(.WIDTH(4), .DEPTH(5)) u_b (
    .clk(clk), .reset(reset_b), .en(en_b), .dir(dir_b), .oneshot(oneshot_b),
    .load(load_b), .load_idx(load_idx_b), .wr_en(wr_en_b), .wr_idx(wr_idx_b),
    .wr_data(wr_data_b), .count(count_b), .idx(idx_b), .tc(tc_b), .done(done_b)
  );

  moore_seq_rom_gen #(.WIDTH(3), .DEPTH(2)) u_c (
    .clk(clk), .reset(reset_c), .en(en_c), .dir(1'b0), .oneshot(1'b0),
    .load(1'b0), .load_idx(1'b0), .wr_en(1'b0), .wr_idx(1'b0),
    .wr_data(3'd0), .count(count_c), .idx(idx_c), .tc(tc_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs to build a, then sample 1 time unit after the edge.
  task automatic drive_a(input logic rs, input logic e, input logic d, input logic o,
                         input logic l, input logic [2:0] li,
                         input logic w, input logic [2:0] wi, input logic [2:0] wd);
    reset_a = rs; en_a = e; dir_a = d; oneshot_a = o;
    load_a = l; load_idx_a = li; wr_en_a = w; wr_idx_a = wi; wr_data_a = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic rs, input logic e, input logic d, input logic o,
                         input logic l, input logic [2:0] li,
                         input logic w, input logic [2:0] wi, input logic [3:0] wd);
    reset_b = rs; en_b = e; dir_b = d; oneshot_b = o;
    load_b = l; load_idx_b = li; wr_en_b = w; wr_idx_b = wi; wr_data_b = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive_a(0, 1, 0, 0, 1, 3'd5, 1, 3'd0, 3'd7);
    checks++;
    if ({idx_a, count_a, tc_a, done_a} !== {3'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got idx=%0d count=%0d tc=%0b done=%0b expected 0 0 0 0",
               idx_a, count_a, tc_a, done_a);
    end
    drive_a(1, 0, 0, 0, 1, 3'd0, 0, 3'd0, 3'd0);
    checks++;
    if (count_a !== 3'd0) begin
      errors++;
      $display("FAIL reset_ignores_write: got count=%0d expected 0", count_a);
    end
  endtask

  task automatic test_free_run_up;
    logic [2:0] ec [10] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0, 3'd1, 3'd3};
    logic [2:0] ei [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    drive_a(0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      drive_a(1, 1, 0, 0, 0, 3'd0, 0, 3'd0, 3'd0);
      checks++;
      if ({idx_a, count_a, tc_a} !== {ei[i], ec[i], (i == 7)}) begin
        errors++;
        $display("FAIL free_run_up[%0d]: got idx=%0d count=%0d tc=%0b expected %0d %0d %0b",
                 i, idx_a, count_a, tc_a, ei[i], ec[i], (i == 7));
      end
    end
  endtask

  task automatic test_down_wrap;
    logic [2:0] ei [3] = '{3'd7, 3'd6, 3'd5};
    logic [2:0] ec [3] = '{3'd4, 3'd5, 3'd7};
    drive_a(0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 1, 1, 0, 0, 3'd0, 0, 3'd0, 3'd0);
      checks++;
      if ({idx_a, count_a, tc_a} !== {ei[i], ec[i], (i == 0)}) begin
        errors++;
        $display("FAIL down_wrap[%0d]: got idx=%0d count=%0d tc=%0b expected %0d %0d %0b",
                 i, idx_a, count_a, tc_a, ei[i], ec[i], (i == 0));
      end
    end
  endtask

  task automatic test_oneshot;
    logic [2:0] ei;
    drive_a(0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 12; i++) begin
      drive_a(1, 1, 0, 1, 0, 3'd0, 0, 3'd0, 3'd0);
      ei = (i < 7) ? 3'(i + 1) : 3'd7;
      checks++;
      if ({idx_a, count_a, tc_a, done_a} !== {ei, g8[ei], (i == 6), (i >= 6)}) begin
        errors++;
        $display("FAIL oneshot_up[%0d]: got idx=%0d count=%0d tc=%0b done=%0b expected %0d %0d %0b %0b",
                 i, idx_a, count_a, tc_a, done_a, ei, g8[ei], (i == 6), (i >= 6));
      end
    end
    // Reverse while done: steps resume, done stays set.
    drive_a(1, 1, 1, 1, 0, 3'd0, 0, 3'd0, 3'd0);
    checks++;
    if ({idx_a, count_a, tc_a, done_a} !== {3'd6, 3'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL oneshot_reverse: got idx=%0d count=%0d tc=%0b done=%0b expected 6 5 0 1",
               idx_a, count_a, tc_a, done_a);
    end
    drive_a(1, 1, 0, 1, 1, 3'd2, 0, 3'd0, 3'd0);
    checks++;
    if ({idx_a, count_a, tc_a, done_a} !== {3'd2, 3'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL oneshot_load: got idx=%0d count=%0d tc=%0b done=%0b expected 2 3 0 0",
               idx_a, count_a, tc_a, done_a);
    end
  endtask

  task automatic test_write_bypass;
    drive_a(0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 3'd0);
    drive_a(1, 0, 0, 0, 1, 3'd3, 1, 3'd3, 3'd5);
    checks++;
    if ({idx_a, count_a} !== {3'd3, 3'd5}) begin
      errors++;
      $display("FAIL write_bypass: got idx=%0d count=%0d expected 3 5", idx_a, count_a);
    end
    drive_a(1, 0, 0, 0, 0, 3'd0, 1, 3'd3, 3'd6);
    checks++;
    if ({idx_a, count_a} !== {3'd3, 3'd5}) begin
      errors++;
      $display("FAIL write_no_refresh: got idx=%0d count=%0d expected 3 5", idx_a, count_a);
    end
    drive_a(1, 0, 0, 0, 1, 3'd3, 0, 3'd0, 3'd0);
    checks++;
    if (count_a !== 3'd6) begin
      errors++;
      $display("FAIL write_persist: got count=%0d expected 6", count_a);
    end
  endtask

  task automatic test_depth5;
    logic [2:0] ei [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    logic [3:0] ec [6] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd0, 4'd1};
    drive_b(0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      drive_b(1, 1, 0, 0, 0, 3'd0, 0, 3'd0, 4'd0);
      checks++;
      if ({idx_b, count_b, tc_b} !== {ei[i], ec[i], (i == 4)}) begin
        errors++;
        $display("FAIL depth5_up[%0d]: got idx=%0d count=%0d tc=%0b expected %0d %0d %0b",
                 i, idx_b, count_b, tc_b, ei[i], ec[i], (i == 4));
      end
    end
    // Out-of-range load is dropped and the step still happens.
    drive_b(1, 1, 0, 0, 1, 3'd6, 0, 3'd0, 4'd0);
    checks++;
    if ({idx_b, count_b, tc_b} !== {3'd2, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL depth5_bad_load_step: got idx=%0d count=%0d tc=%0b expected 2 3 0",
               idx_b, count_b, tc_b);
    end
    drive_b(1, 0, 0, 0, 1, 3'd7, 1, 3'd5, 4'hf);
    checks++;
    if ({idx_b, count_b} !== {3'd2, 4'd3}) begin
      errors++;
      $display("FAIL depth5_bad_load_hold: got idx=%0d count=%0d expected 2 3", idx_b, count_b);
    end
    drive_b(1, 0, 0, 0, 1, 3'd4, 0, 3'd0, 4'd0);
    checks++;
    if ({idx_b, count_b} !== {3'd4, 4'd6}) begin
      errors++;
      $display("FAIL depth5_load_last: got idx=%0d count=%0d expected 4 6", idx_b, count_b);
    end
    // One-shot down already at terminal index 0: en ignored.
    drive_b(0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 4'd0);
    drive_b(1, 1, 1, 1, 0, 3'd0, 0, 3'd0, 4'd0);
    checks++;
    if ({idx_b, count_b, tc_b, done_b} !== {3'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL depth5_oneshot_at_term: got idx=%0d count=%0d tc=%0b done=%0b expected 0 0 0 0",
               idx_b, count_b, tc_b, done_b);
    end
  endtask

  task automatic test_mid_reset;
    drive_a(0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 3'd0);
    drive_a(1, 0, 0, 0, 0, 3'd0, 1, 3'd1, 3'd7);
    drive_a(1, 0, 0, 0, 1, 3'd1, 0, 3'd0, 3'd0);
    checks++;
    if (count_a !== 3'd7) begin
      errors++;
      $display("FAIL mid_reset_written: got count=%0d expected 7", count_a);
    end
    drive_a(1, 1, 0, 1, 0, 3'd0, 0, 3'd0, 3'd0);
    drive_a(1, 1, 0, 1, 0, 3'd0, 0, 3'd0, 3'd0);
    drive_a(0, 1, 0, 1, 0, 3'd0, 1, 3'd2, 3'd0);
    checks++;
    if ({idx_a, count_a, tc_a, done_a} !== {3'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_state: got idx=%0d count=%0d tc=%0b done=%0b expected 0 0 0 0",
               idx_a, count_a, tc_a, done_a);
    end
    drive_a(1, 0, 0, 0, 1, 3'd1, 0, 3'd0, 3'd0);
    checks++;
    if (count_a !== 3'd1) begin
      errors++;
      $display("FAIL mid_reset_table1: got count=%0d expected 1", count_a);
    end
    drive_a(1, 0, 0, 0, 1, 3'd2, 0, 3'd0, 3'd0);
    checks++;
    if (count_a !== 3'd3) begin
      errors++;
      $display("FAIL mid_reset_table2: got count=%0d expected 3", count_a);
    end
  endtask

  task automatic test_back_to_back;
    reset_c = 1'b0; en_c = 1'b1;
    @(posedge clk);
    #1;
    reset_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({idx_c, count_c, tc_c} !== {1'(i % 2 == 0), 3'(i % 2 == 0), (i % 2 == 1)}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got idx=%0d count=%0d tc=%0b expected %0d %0d %0b",
                 i, idx_c, count_c, tc_c, (i % 2 == 0), (i % 2 == 0), (i % 2 == 1));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_c = 1'b0; en_c = 1'b0;
    drive_b(0, 0, 0, 0, 0, 3'd0, 0, 3'd0, 4'd0);
    test_reset;
    test_free_run_up;
    test_down_wrap;
    test_oneshot;
    test_write_bypass;
    test_depth5;
    test_mid_reset;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
